// File: rtl/rgb_pattern_gen.sv
// rgb_pattern_gen: recovers pixel coordinates from timing strobes and emits one of four test patterns
module rgb_pattern_gen #(
  parameter int P_RES_X      = 640,
  parameter int P_RES_Y      = 480,
  parameter int P_CHECK_LOG2 = 5,
  parameter int P_BOX_SIZE   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_blank,
  input  logic [1:0] i_pattern,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic [7:0] o_frame_cnt
);
  localparam logic [11:0] X_MAX  = 12'(P_RES_X - 1);
  localparam logic [11:0] Y_MAX  = 12'(P_RES_Y - 1);
  localparam logic [11:0] BOX    = 12'(P_BOX_SIZE);
  localparam logic [11:0] BX_MOD = 12'(P_RES_X - P_BOX_SIZE);
  localparam logic [11:0] BY     = 12'((P_RES_Y - P_BOX_SIZE) / 2);
  localparam logic [23:0] BAR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        hs1, vs1, bl1, sync_ok, first_line;
  logic        frame_start, line_start, in_box;
  logic [1:0]  pat_q;
  logic [11:0] x, y, bx, bx_inc;
  logic [2:0]  bar;
  logic [23:0] rgb;

  assign frame_start = i_vsync & ~vs1;
  assign line_start  = ~i_blank & bl1;
  assign bx_inc      = bx + 12'd2;
  assign in_box      = (x >= bx) && (x < bx + BOX) && (y >= BY) && (y < BY + BOX);

  // stage 1: strobe history, coordinate recovery and per-frame state (counter, pattern, box position)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {hs1, vs1, bl1, sync_ok, first_line} <= '0;
      x           <= '0;
      y           <= '0;
      bx          <= '0;
      pat_q       <= '0;
      o_frame_cnt <= '0;
    end else begin
      {hs1, vs1, bl1} <= {i_hsync, i_vsync, i_blank};
      if (frame_start) begin
        sync_ok     <= 1'b1;
        o_frame_cnt <= o_frame_cnt + 8'd1;
        pat_q       <= i_pattern;
        bx          <= (o_frame_cnt == 8'hFF) ? '0 : (bx_inc >= BX_MOD) ? bx_inc - BX_MOD : bx_inc;
      end
      first_line <= frame_start ? ~line_start : first_line & ~line_start;
      if (line_start) begin
        x <= '0;
        y <= (frame_start || first_line) ? '0 : (y < Y_MAX) ? y + 12'd1 : y;
      end else if (!i_blank && x < X_MAX) x <= x + 12'd1;
    end
  end

  // pattern colour for the stage-1 pixel; bar index from threshold compares instead of a divider
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) if (x >= 12'(k * P_RES_X / 8)) bar = 3'(k);
    rgb = (pat_q == 2'd0) ? BAR[bar] :
          (pat_q == 2'd1) ? {24{x[P_CHECK_LOG2] ^ y[P_CHECK_LOG2]}} :
          (pat_q == 2'd2) ? {x[9:2], y[8:1], o_frame_cnt} :
          in_box ? 24'hFFFFFF : 24'h0000FF;
  end

  // stage 2: register colour alongside the twice-delayed strobes, black when blanked or unsynced
  always_ff @(posedge i_clk) begin
    if (i_rst) {o_hsync, o_vsync, o_blank, o_red, o_green, o_blue} <= '0;
    else begin
      {o_hsync, o_vsync, o_blank} <= {hs1, vs1, bl1};
      {o_red, o_green, o_blue}    <= (bl1 || !sync_ok) ? 24'h000000 : rgb;
    end
  end
endmodule

// File: tb/tb_rgb_pattern_gen.sv
// tb_rgb_pattern_gen: scoreboard bench for rgb_pattern_gen with directed pixel expectations
`timescale 1ns/1ps
module tb_rgb_pattern_gen;
  logic       i_clk = 1'b0;
  logic       i_rst, i_hsync, i_vsync, i_blank;
  logic [1:0] i_pattern;
  logic       o_hsync, o_vsync, o_blank;
  logic [7:0] o_red, o_green, o_blue, o_frame_cnt;

  rgb_pattern_gen dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
    .i_pattern(i_pattern), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        care;
    logic [23:0] rgb;
    int          x;
    int          y;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ly = 0;
  logic        black_all = 1'b0;
  logic        care_at [1024];
  logic [23:0] exp_at [1024];
  logic [2:0]  d1 = '0;
  logic [2:0]  d2 = '0;
  logic        r1 = 1'b1;
  logic        r2 = 1'b1;

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic mark(input int x, input logic [23:0] v);
    care_at[x] = 1'b1;
    exp_at[x]  = v;
  endtask

  task automatic run_line(input int n);
    exp_t e;
    step(); i_blank = 1'b1; i_hsync = 1'b1;
    step(); i_hsync = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      step();
      i_blank = 1'b0;
      e.care = black_all | care_at[i];
      e.rgb  = black_all ? 24'h000000 : exp_at[i];
      e.x    = i;
      e.y    = ly;
      sb_q.push_back(e);
      care_at[i] = 1'b0;
    end
    step(); i_blank = 1'b1;
    ly++;
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) run_line(1);
  endtask

  task automatic vsync_pulse();
    step(); i_blank = 1'b1; i_vsync = 1'b1;
    step();
    step(); i_vsync = 1'b0;
    step();
    ly = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(); i_blank = 1'b1; i_hsync = 1'b0; i_vsync = 1'b0;
    end
  endtask

  // reference strobe delay line and reset guard
  always @(posedge i_clk) begin
    d1 <= {i_hsync, i_vsync, i_blank};
    d2 <= d1;
    r1 <= i_rst;
    r2 <= r1;
  end

  // monitor: strobe alignment, black during blank, and scoreboard pops on each active output pixel
  always @(negedge i_clk) begin
    exp_t e;
    if (!(i_rst || r1 || r2)) begin
      chk("align", 36'({o_hsync, o_vsync, o_blank}), 36'(d2));
      if (o_blank) chk("blank_rgb", 36'({o_red, o_green, o_blue}), 36'd0);
      else begin
        n_chk++;
        if (sb_q.size() == 0) $display("FAIL unexpected_pixel got=%h exp=none", {o_red, o_green, o_blue});
        else begin
          e = sb_q.pop_front();
          if (!e.care || {o_red, o_green, o_blue} === e.rgb) n_pass++;
          else $display("FAIL pix(%0d,%0d) got=%h exp=%h", e.x, e.y, {o_red, o_green, o_blue}, e.rgb);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bx;
    for (int i = 0; i < 1024; i++) begin
      care_at[i] = 1'b0;
      exp_at[i]  = '0;
    end
    i_rst = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_blank = 1'b0; i_pattern = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reset_out", 36'({o_hsync, o_vsync, o_blank, o_red, o_green, o_blue, o_frame_cnt}), 36'd0);
      if (i == 1) begin
        i_hsync = 1'b0; i_vsync = 1'b0; i_blank = 1'b1;
      end
    end
    i_rst = 1'b0;
    idle(3);
    black_all = 1'b1;
    run_line(16);
    run_line(16);
    black_all = 1'b0;
    chk("fc_pre_sync", 36'(o_frame_cnt), 36'd0);

    i_pattern = 2'd0;
    vsync_pulse();
    chk("fc_first", 36'(o_frame_cnt), 36'd1);
    short_lines(100);
    mark(0, 24'hFFFFFF); mark(79, 24'hFFFFFF); mark(80, 24'hFFFF00); mark(159, 24'hFFFF00);
    mark(160, 24'h00FFFF); mark(320, 24'hFF00FF); mark(400, 24'hFF0000); mark(480, 24'h0000FF);
    mark(560, 24'h000000); mark(639, 24'h000000);
    run_line(640);

    i_pattern = 2'd1;
    vsync_pulse();
    chk("fc_chk", 36'(o_frame_cnt), 36'd2);
    mark(0, 24'h000000); mark(32, 24'hFFFFFF);
    run_line(33);
    short_lines(31);
    mark(32, 24'h000000);
    run_line(33);
    short_lines(30);
    mark(31, 24'hFFFFFF);
    run_line(32);
    short_lines(136);
    i_pattern = 2'd2;
    mark(0, 24'h000000); mark(32, 24'hFFFFFF);
    run_line(33);
    mark(8, 24'h000000);
    run_line(9);
    short_lines(5);

    vsync_pulse();
    chk("fc_grad", 36'(o_frame_cnt), 36'd3);
    mark(0, 24'h000003);
    run_line(1);
    short_lines(3);
    mark(8, 24'h020203);
    run_line(9);
    mark(8, 24'h020203); mark(12, 24'h030203);
    run_line(13);

    idle(3);
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
    idle(3);
    black_all = 1'b1;
    run_line(16);
    black_all = 1'b0;
    chk("fc_after_rst", 36'(o_frame_cnt), 36'd0);

    i_pattern = 2'd3;
    for (int f = 1; f <= 300; f++) begin
      vsync_pulse();
      chk("fc_box", 36'(o_frame_cnt), 36'(f % 256));
      if (f == 1 || f == 2 || f == 100 || f == 255 || f == 256 || f == 257 || f == 300) begin
        bx = (2 * (f % 256)) % 576;
        short_lines(207);
        mark(0, 24'h0000FF);
        run_line(1);
        mark(bx, 24'hFFFFFF);
        if (bx > 0) mark(bx - 1, 24'h0000FF);
        mark(bx + 63, 24'hFFFFFF);
        mark(bx + 64, 24'h0000FF);
        run_line(bx + 65);
      end
    end
    idle(10);
    chk("sb_drain", 36'(sb_q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
